// File: rtl/line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// line_buf_ctrl
//
// Purpose:
//     Controller for a two-line buffer that turns a raster pixel stream into
//     3-row vertical windows (rows n-2, n-1, n) one column at a time. Two
//     external single-port RAMs of depth IMG_W hold the two previous lines;
//     the incoming line overwrites the older of the two while both are read
//     at the same column address.
//
// Ports:
//     clk, rst             clock and asynchronous active-high reset
//     in_sof, in_valid     start-of-frame qualifier and pixel strobe
//     in_data              raw pixel
//     ram_addr             shared column address for both RAMs
//     ram_wr_en            per-RAM write enable (bit = RAM index)
//     ram_wr_data          write data common to both RAMs
//     ram_rd_en            read enable common to both RAMs
//     ram_rd_data0/1       RAM read data, one-cycle latency
//     out_valid            window column valid
//     out_top/mid/bot      rows n-2 / n-1 / n of the same column
//     out_col              column of the current window
//     out_win_ok           window is complete (row >= 2)
//     out_err              one-cycle pulse when in_sof arrives mid-line
//     out_eof              (LB_EOF_EN only) pulses with the last pixel of frame
//
// Configuration:
//     LB_EOF_EN  when defined, adds out_eof and returns to IDLE at the end of
//                each IMG_H-line frame; otherwise RUN persists across frames.
// -----------------------------------------------------------------------------
module line_buf_ctrl #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 1024,
    parameter int IMG_H = 768,
    localparam int A_WID = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_sof,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [A_WID-1:0] ram_addr,
    output logic [1:0]       ram_wr_en,
    output logic [WIDTH-1:0] ram_wr_data,
    output logic             ram_rd_en,
    input  logic [WIDTH-1:0] ram_rd_data0,
    input  logic [WIDTH-1:0] ram_rd_data1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_top,
    output logic [WIDTH-1:0] out_mid,
    output logic [WIDTH-1:0] out_bot,
    output logic [A_WID-1:0] out_col,
    output logic             out_win_ok,
`ifdef LB_EOF_EN
    output logic             out_eof,
`endif
    output logic             out_err
);

    // Row counter needs at least two bits so "row >= 2" is representable.
    localparam int ROW_W = (IMG_H > 4) ? $clog2(IMG_H) : 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [A_WID-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               wsel_q, wsel_d;
    logic               rdSel_q;
    logic               outValid_q;
    logic [WIDTH-1:0]   outBot_q;
    logic [A_WID-1:0]   outCol_q;
    logic               winOk_q;
    logic               err_q;
    logic               eof_q;

    logic               sofHit;
    logic               accept;
    logic               lastCol;
    logic [A_WID-1:0]   colEff;
    logic               wselEff;
    logic               winHit;
    logic               errHit;
    logic               eofHit;

    // A start-of-frame pixel is always taken as column 0 of a fresh frame
    // written into RAM 0, so address and select are overridden for it before
    // the registered counters have caught up.
    always_comb begin
        sofHit  = in_valid & in_sof;
        accept  = in_valid & ((state_q != IDLE) | in_sof);
        lastCol = (col_q == A_WID'(IMG_W - 1));
        colEff  = sofHit ? '0 : col_q;
        wselEff = sofHit ? 1'b0 : wsel_q;
        winHit  = accept & ~sofHit & (state_q == RUN);
        errHit  = sofHit & (state_q != IDLE) & (col_q != '0);
    end

    // RAM side is purely combinational from the current pixel. Reading and
    // writing the same address in one cycle relies on the RAM returning the
    // old contents, which is exactly the row two lines back.
    always_comb begin
        ram_addr    = colEff;
        ram_wr_data = in_data;
        ram_rd_en   = accept & ~rst;
        ram_wr_en   = 2'b00;
        if (accept && !rst) begin
            ram_wr_en[wselEff] = 1'b1;
        end
    end

    // Next-state logic: column/row/write-select bookkeeping and the
    // IDLE -> FILL -> RUN progression. in_sof takes priority over a wrap.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wsel_d  = wsel_q;
        eofHit  = 1'b0;
        if (sofHit) begin
            state_d = FILL;
            col_d   = A_WID'(1);
            row_d   = '0;
            wsel_d  = 1'b0;
        end else if (accept) begin
            if (lastCol) begin
                col_d  = '0;
                row_d  = (&row_q) ? row_q : row_q + ROW_W'(1);
                wsel_d = ~wsel_q;
                if (state_q == FILL && row_q == ROW_W'(1)) begin
                    state_d = RUN;
                end
`ifdef LB_EOF_EN
                if (row_q == ROW_W'(IMG_H - 1)) begin
                    eofHit  = 1'b1;
                    state_d = IDLE;
                end
`endif
            end else begin
                col_d = col_q + A_WID'(1);
            end
        end
    end

    // State and position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wsel_q  <= wsel_d;
        end
    end

    // Output pipeline: everything lines up with the RAM read data, which
    // arrives one cycle after the pixel that addressed it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdSel_q    <= 1'b0;
            outValid_q <= 1'b0;
            outBot_q   <= '0;
            outCol_q   <= '0;
            winOk_q    <= 1'b0;
            err_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            outValid_q <= accept;
            winOk_q    <= winHit;
            err_q      <= errHit;
            eof_q      <= eofHit;
            if (accept) begin
                rdSel_q  <= wselEff;
                outBot_q <= in_data;
                outCol_q <= colEff;
            end
        end
    end

    // The RAM being overwritten holds row n-2; the other holds row n-1.
    // Both are forced to zero while reset is held so the window stays quiet.
    always_comb begin
        out_top = '0;
        out_mid = '0;
        if (!rst) begin
            out_top = rdSel_q ? ram_rd_data1 : ram_rd_data0;
            out_mid = rdSel_q ? ram_rd_data0 : ram_rd_data1;
        end
    end

    assign out_valid  = outValid_q;
    assign out_bot    = outBot_q;
    assign out_col    = outCol_q;
    assign out_win_ok = winOk_q;
    assign out_err    = err_q;
`ifdef LB_EOF_EN
    assign out_eof    = eof_q;
`else
    logic unusedEof;
    assign unusedEof = eof_q;
`endif

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: pixel bit width.
REQ-002 Parameter IMG_W, default 1024: pixels per line; both external RAMs are sized DEPTH=IMG_W.
REQ-003 Parameter IMG_H, default 768: lines per frame (used only under REQ-030).
REQ-004 Local A_WID = $clog2(IMG_W).
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_sof  input  1  qualifies the first pixel of a frame; valid only with in_valid.
REQ-008 in_valid  input  1  input pixel strobe.
REQ-009 in_data  input  WIDTH  raw pixel.
REQ-010 ram_addr  output  A_WID  shared read/write column address for both RAMs.
REQ-011 ram_wr_en  output  2  per-RAM write enable.
REQ-012 ram_wr_data  output  WIDTH  write data, common to both RAMs.
REQ-013 ram_rd_en  output  1  read enable, common to both RAMs.
REQ-014 ram_rd_data0 / ram_rd_data1  input  WIDTH each  RAM read data, 1-cycle latency, held while rd_en is low.
REQ-015 out_valid  output  1  window column valid.
REQ-016 out_top / out_mid / out_bot  output  WIDTH each  rows n-2 / n-1 / n, same column.
REQ-017 out_col  output  A_WID  column of the current output.
REQ-018 out_win_ok  output  1  high when out_valid and row >= 2.
REQ-019 out_err  output  1  one-cycle pulse on a protocol error.

Function
REQ-020 Datapath: ram_addr=col, ram_rd_en=in_valid, ram_wr_data=in_data, ram_wr_en[wsel]=in_valid, all combinational; same-address read returns pre-write data.
REQ-021 col increments on each accepted pixel and wraps IMG_W-1 -> 0; on wrap, row increments (saturates at all-ones) and wsel toggles.
REQ-022 FSM IDLE: pixels ignored, no RAM access; in_valid&in_sof -> FILL with col=0, row=0, wsel=0, and that pixel accepted as col 0.
REQ-023 FSM FILL (row<2): pixels are written and read, out_win_ok=0; wrap of row 1 -> RUN.
REQ-024 FSM RUN: out_win_ok=out_valid; remains until reset, in_sof, or REQ-030.
REQ-025 Latency: out_valid, out_bot and out_col are in_valid, in_data and col registered by 1 cycle; wsel_d is wsel registered on in_valid; out_top=wsel_d ? ram_rd_data1 : ram_rd_data0; out_mid is the other RAM.
REQ-026 in_sof in FILL/RUN restarts per REQ-022; if col!=0 at that time, out_err pulses next cycle.
REQ-027 A wrap and in_sof on the same pixel: in_sof wins.

Reset
REQ-028 rst asserted: FSM=IDLE; col, row, wsel, wsel_d=0; out_valid, out_bot, out_col, out_win_ok, out_err=0; ram_wr_en=0, ram_rd_en=0 regardless of inputs.
REQ-029 rst mid-line discards partial state; the next frame requires in_sof; RAM contents are not cleared.

Configuration
REQ-030 Macro LB_EOF_EN defined: add output out_eof (1 bit) that pulses with out_valid for the pixel at col=IMG_W-1, row=IMG_H-1; the FSM then returns to IDLE, and in_valid without in_sof is ignored until the next in_sof.
REQ-031 LB_EOF_EN undefined: no out_eof port; IMG_H is unused; RUN persists across frames.

Verification
REQ-032 IMG_W=4, frame of 3 lines with in_data=row*16+col -> on third line, out_top/out_mid/out_bot = 0x0c/0x1c/0x2c at out_col=0..3; out_win_ok high only on these 4 cycles.
REQ-033 Gapped in_valid (1-on/2-off) on the same frame -> identical out_* values; out_valid count equals 12.
REQ-034 in_sof at col=2 of line 1 -> out_err=1 for one cycle; row=0, col=1 after that pixel; out_win_ok low for the next 2 lines.
REQ-035 rst pulse for 1 cycle mid-line 2 -> all outputs 0 during rst; subsequent in_valid without in_sof produces no ram_wr_en.
REQ-036 LB_EOF_EN, IMG_W=4, IMG_H=3 -> out_eof high exactly with out_col=3 of line 2; following pixels without in_sof ignored.
